md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameters MULT_CYC, default 5, multiply latency in busy cycles; DIV_CYC, default 10, divide latency in busy cycles.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port start  input  1  E-stage MD instruction valid this cycle.
REQ-005 SHALL have port md_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-006 SHALL have port rs_data  input  32  forwarded E-stage rs operand.
REQ-007 SHALL have port rt_data  input  32  forwarded E-stage rt operand.
REQ-008 SHALL have port cancel  input  1  exception/interrupt flush; suppresses this cycle's start.
REQ-009 SHALL have port busy  output  1  registered; high while a mult/div is in flight.
REQ-010 SHALL have port md_stall  output  1  combinational stall request to the hazard unit.
REQ-011 SHALL have port hi  output  32  architectural HI register.
REQ-012 SHALL have port lo  output  32  architectural LO register.
REQ-013 SHALL have port md_rdata  output  32  combinational mfhi/mflo read data.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, with a down-counter cnt of at least 4 bits.
REQ-015 SHALL define accept = start && !cancel && state==IDLE.
REQ-016 SHALL, on accept with op 1/2 at edge t: load cnt=MULT_CYC; latch the 64-bit product (op 1 signed, op 2 unsigned) into temp; go to MUL.
REQ-017 SHALL, on accept with op 3/4 at edge t: load cnt=DIV_CYC; latch quotient/remainder (op 3 signed, op 4 unsigned) into temp; go to DIV.
REQ-018 SHALL, in MUL/DIV, decrement cnt each edge; at the edge where cnt==1, write temp to HI/LO and return to IDLE.
REQ-019 SHALL set busy=1 exactly for states MUL/DIV: MULT_CYC cycles for mult, DIV_CYC for div; new HI/LO visible in the first cycle busy=0.
REQ-020 SHALL compute multiplication as HI=product[63:32], LO=product[31:0].
REQ-021 SHALL compute division as LO=quotient truncated toward zero, HI=remainder with sign of dividend (signed); for divisor 0, HI/LO SHALL be left unchanged but the full DIV_CYC busy period still SHALL run.
REQ-022 SHALL compute signed 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-023 SHALL, on accept with op 5 (mthi)/6 (mtlo), write rs_data to HI/LO at that edge, with no busy period.
REQ-024 SHALL assign md_stall = busy || (start && op in 1..8 && state!=IDLE) || (start && op in 1..4 && !cancel); ops 5-8 SHALL stall only while busy.
REQ-025 SHALL assign md_rdata = hi for op 7, lo for op 8, else 0; reads SHALL reflect current registered HI/LO.
REQ-026 SHALL ignore start while not IDLE (no state change); the requester is held by md_stall.
REQ-027 SHALL NOT abort an in-flight operation on cancel; cancel SHALL gate acceptance only.

Reset
REQ-028 SHALL, when reset==0 at an edge, set state=IDLE, cnt=0, busy=0, hi=0, lo=0, temp=0, overriding any simultaneous start.
REQ-029 SHALL discard an in-flight operation on reset mid-operation; HI/LO SHALL stay 0 afterward.

Verification
REQ-030 SHALL cover mult: rs=0xFFFFFFFF, rt=2, op=1 start one cycle -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; op=2 same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 SHALL cover signed div: rs=-7, rt=2, op=3 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu of 7/0 -> hi/lo unchanged after 10 busy cycles.
REQ-032 SHALL cover stall: start mflo at busy cycle 3 of a mult -> md_stall=1 until busy=0, then md_rdata=new lo.
REQ-033 SHALL cover cancel: start=1, op=1, cancel=1 -> md_stall=0, busy stays 0, hi/lo unchanged; cancel=1 during busy -> operation still completes.
REQ-034 SHALL cover mthi/mtlo: op=5, rs=0x12345678 -> hi=0x12345678 next cycle, busy=0, md_stall=0.
REQ-035 SHALL cover reset mid-op: reset=0 at busy cycle 4 of a div -> next cycle busy=0, hi=lo=0; a new mult then completes normally.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   mult/multu/div/divu compute their result at acceptance, then hold the
//   unit busy for a fixed latency before committing to HI/LO. mthi/mtlo
//   write HI/LO immediately. mfhi/mflo read HI/LO combinationally.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-low
//   start     in   E-stage MD instruction valid
//   md_op     in   [3:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                        5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   rs_data   in   [31:0] rs operand
//   rt_data   in   [31:0] rt operand
//   cancel    in   flush; blocks acceptance this cycle only
//   busy      out  registered, high while mult/div in flight
//   md_stall  out  combinational stall request
//   hi, lo    out  [31:0] architectural HI/LO
//   md_rdata  out  [31:0] mfhi/mflo read data
module md_sequencer #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cancel,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYC  = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int NEED_W   = $clog2(MAX_CYC + 1);
    localparam int CNT_W    = (NEED_W > 4) ? NEED_W : 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        temp;
    logic               temp_wr;   // cleared for divide-by-zero: HI/LO untouched

    logic               accept;
    logic               op_muldiv;
    logic               op_any;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        dvd;
    logic [31:0]        dvs;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign accept    = start && !cancel && (state == IDLE);
    assign op_muldiv = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign op_any    = (md_op >= OP_MULT) && (md_op <= OP_MFLO);

    assign md_stall = busy
                   || (start && op_any && (state != IDLE))
                   || (start && op_muldiv && !cancel);

    always_comb begin
        md_rdata = '0;
        if (md_op == OP_MFHI)
            md_rdata = hi;
        else if (md_op == OP_MFLO)
            md_rdata = lo;
    end

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data})
                  * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

    // Signed divide runs on magnitudes through the single unsigned divider,
    // then signs are restored. This makes 0x80000000 / -1 fall out naturally
    // (magnitude 0x80000000, same signs -> 0x80000000, remainder 0).
    always_comb begin
        div_signed = (md_op == OP_DIV);
        abs_a      = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
        abs_b      = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
        dvd        = div_signed ? abs_a : rs_data;
        dvs        = div_signed ? abs_b : rt_data;
        uq         = '0;
        ur         = '0;
        if (dvs != '0) begin
            uq = dvd / dvs;
            ur = dvd % dvs;
        end
        quot = uq;
        rem  = ur;
        if (div_signed) begin
            if (rs_data[31] ^ rt_data[31])
                quot = ~uq + 32'd1;
            if (rs_data[31])
                rem = ~ur + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            temp    <= '0;
            temp_wr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                temp    <= (md_op == OP_MULT) ? prod_s : prod_u;
                                temp_wr <= 1'b1;
                                cnt     <= CNT_W'(MULT_CYC);
                                busy    <= 1'b1;
                                state   <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                temp    <= {rem, quot};
                                temp_wr <= (rt_data != '0);
                                cnt     <= CNT_W'(DIV_CYC);
                                busy    <= 1'b1;
                                state   <= DIV;
                            end
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (temp_wr) begin
                            hi <= temp[63:32];
                            lo <= temp[31:0];
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    always #5 clk = ~clk;

    md_sequencer #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .cancel   (cancel),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural HI/LO, remaining busy cycles and the
    // result pending commit when the busy period ends.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic        p_wr = 1'b0;
    int          m_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model
    // by the upcoming rising edge, then step past that edge.
    task automatic cycle(input logic rst_n, input logic st, input logic cn,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr, sp;
        longint unsigned ua, ub, uq, ur, up;
        logic            exp_busy, exp_stall;
        logic [31:0]     exp_rd;
        reset = rst_n; start = st; cancel = cn; md_op = op; rs_data = a; rt_data = b;
        #4;
        exp_busy  = (m_left > 0);
        exp_stall = exp_busy || (st && !cn && op >= 4'd1 && op <= 4'd4);
        exp_rd    = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        chk("busy",     {31'b0, busy},     {31'b0, exp_busy});
        chk("md_stall", {31'b0, md_stall}, {31'b0, exp_stall});
        chk("md_rdata", md_rdata, exp_rd);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);

        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st && !cn) begin
            case (op)
                4'd1: begin
                    sp = sa * sb;
                    p_hi = sp[63:32]; p_lo = sp[31:0]; p_wr = 1'b1; m_left = MULT_CYC;
                end
                4'd2: begin
                    up = ua * ub;
                    p_hi = up[63:32]; p_lo = up[31:0]; p_wr = 1'b1; m_left = MULT_CYC;
                end
                4'd3: begin
                    m_left = DIV_CYC;
                    p_wr   = (b != 0);
                    if (b != 0) begin
                        sq = sa / sb; sr = sa % sb;
                        p_lo = sq[31:0]; p_hi = sr[31:0];
                    end
                end
                4'd4: begin
                    m_left = DIV_CYC;
                    p_wr   = (b != 0);
                    if (b != 0) begin
                        uq = ua / ub; ur = ua % ub;
                        p_lo = uq[31:0]; p_hi = ur[31:0];
                    end
                end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; cancel = 1'b0; md_op = 4'd0;
        rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state, including reset overriding a simultaneous start
        cycle(1'b0, 1'b1, 1'b0, 4'd1, 32'd3, 32'd4);
        idle(1);

        // mult / multu of 0xFFFFFFFF * 2
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_CYC);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        cycle(1'b1, 1'b1, 1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_CYC);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // signed div -7 / 2, then divu by zero
        cycle(1'b1, 1'b1, 1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_CYC);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 1'b0, 4'd4, 32'd7, 32'd0);
        idle(DIV_CYC);
        chk("div0_lo", lo, 32'hFFFF_FFFD);
        chk("div0_hi", hi, 32'hFFFF_FFFF);

        // overflow case
        cycle(1'b1, 1'b1, 1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_CYC);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0000_0000);

        // mflo held off during a mult, reads new lo once idle
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'd6, 32'd7);
        idle(2);
        for (int i = 0; i < MULT_CYC - 2; i++)
            cycle(1'b1, 1'b1, 1'b0, 4'd8, 32'd0, 32'd0);
        #0 reset = 1'b1; start = 1'b1; md_op = 4'd8; #4;
        chk("mflo_after", md_rdata, 32'd42);
        chk("mflo_nostall", {31'b0, md_stall}, 32'd0);
        @(posedge clk); #1;

        // cancel blocks acceptance, but not an in-flight op
        cycle(1'b1, 1'b1, 1'b1, 4'd1, 32'd9, 32'd9);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 4'd2, 32'd10, 32'd11);
        cycle(1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 4'd1, 32'd5, 32'd5);
        idle(MULT_CYC - 2);
        chk("cancel_lo", lo, 32'd110);

        // mthi / mtlo
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 32'h1234_5678, 32'd0);
        chk("mthi", hi, 32'h1234_5678);
        cycle(1'b1, 1'b1, 1'b0, 4'd6, 32'hCAFE_F00D, 32'd0);
        chk("mtlo", lo, 32'hCAFE_F00D);

        // reset mid-divide, then a fresh mult completes
        cycle(1'b1, 1'b1, 1'b0, 4'd3, 32'd100, 32'd3);
        idle(3);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        idle(DIV_CYC);
        chk("rst_hi_stays", hi, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'd3, 32'hFFFF_FFFE);
        idle(MULT_CYC);
        chk("post_rst_lo", lo, 32'hFFFF_FFFA);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r_st, r_cn, r_rst;
            logic [3:0] r_op;
            r_st  = ($urandom_range(0, 1) == 1);
            r_op  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 8))
                                                 : 4'($urandom_range(0, 15));
            r_cn  = ($urandom_range(0, 9) == 0);
            r_rst = ($urandom_range(0, 149) != 0);
            cycle(r_rst, r_st, r_cn, r_op, pick(), pick());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
